// File: rtl/bin_to_bcd_display_if.sv
// Request/result bundle between a display driver and the binary-to-BCD converter.
//
// Handshake: the master raises iSTART with iBIN valid; the converter accepts on
// any rising clock edge where iSTART=1 and oBUSY=0, sampling iBIN only on that
// edge. oBUSY stays high from the cycle after acceptance through the oDONE
// cycle, during which further iSTART requests are ignored (never queued).
// oDONE is a one-cycle pulse marking the cycle oBCD/oBLANK/oOVF take their new
// values; those outputs are otherwise held.
interface bin_to_bcd_display_if #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
);
    logic                  iSTART;
    logic [BIN_W-1:0]      iBIN;
    logic                  oBUSY;
    logic                  oDONE;
    logic [4*DIGITS-1:0]   oBCD;
    logic [DIGITS-1:0]     oBLANK;
    logic                  oOVF;

    modport master (
        output iSTART, iBIN,
        input  oBUSY, oDONE, oBCD, oBLANK, oOVF
    );

    modport slave (
        input  iSTART, iBIN,
        output oBUSY, oDONE, oBCD, oBLANK, oOVF
    );
endinterface

// File: rtl/bin_to_bcd_display.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) feeding
// the per-digit 7-segment decoders, plus a leading-zero blank mask.
// Outputs only change at reset or when a conversion completes, so decoders
// never see a partially converted value.
module bin_to_bcd_display #(
    parameter int BIN_W    = 20,
    parameter int DIGITS   = 6,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    bin_to_bcd_display_if.slave      conv,
    output logic [1:0]               oDBG_STATE
);
    localparam int SRW = 4 * DIGITS + BIN_W;
    localparam int CW  = $clog2(BIN_W + 1);

    // 10^n - 1 computed in 64 bits so the overflow limit never wraps.
    function automatic logic [63:0] max_value(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    localparam logic [63:0]         MAX_VAL   = max_value(DIGITS);
    localparam logic [CW-1:0]       LAST_CNT  = CW'(BIN_W - 1);
    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};
    localparam logic [DIGITS-1:0]   BLANK_RST = LZ_BLANK ? ({DIGITS{1'b1}} << 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                state_q;
    logic [SRW-1:0]        sr_q, sr_d;
    logic [CW-1:0]         cnt_q;
    logic                  ovf_q, ovf_d;
    logic                  busy_q;
    logic                  done_q;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [DIGITS-1:0]     blank_q, blank_d;
    logic                  ovf_out_q;
    logic [4*DIGITS-1:0]   adj;
    logic                  all_zero;

    // Overflow is decided from the raw input at acceptance time.
    always_comb begin
        ovf_d = (64'(conv.iBIN) > MAX_VAL);
    end

    // One double-dabble step: add 3 to every nibble >= 5, then shift left.
    // Bits leaving the top digit are dropped (only matters on overflow).
    always_comb begin
        adj = sr_q[SRW-1 -: 4*DIGITS];
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        sr_d = {adj, sr_q[BIN_W-1:0]} << 1;
    end

    // Final digits as seen after the last shift, saturated on overflow.
    always_comb begin
        bcd_d = ovf_q ? ALL_NINES : sr_d[SRW-1 -: 4*DIGITS];
    end

    // Leading-zero mask: digit i blanks when it and every digit above it is 0.
    // The units digit always shows, and an overflowed reading shows all nines.
    always_comb begin
        blank_d  = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero   = all_zero & (bcd_d[4*i +: 4] == 4'd0);
            blank_d[i] = all_zero;
        end
        if (ovf_q || !LZ_BLANK) blank_d = '0;
    end

    // Control FSM with registered outputs. The result registers load on the
    // edge entering DONE so they are valid in the same cycle as oDONE.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            blank_q   <= BLANK_RST;
            ovf_out_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (conv.iSTART) begin
                        sr_q    <= {{(4*DIGITS){1'b0}}, conv.iBIN};
                        cnt_q   <= '0;
                        ovf_q   <= ovf_d;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        bcd_q     <= bcd_d;
                        blank_q   <= blank_d;
                        ovf_out_q <= ovf_q;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign conv.oBUSY  = busy_q;
    assign conv.oDONE  = done_q;
    assign conv.oBCD   = bcd_q;
    assign conv.oBLANK = blank_q;
    assign conv.oOVF   = ovf_out_q;
    assign oDBG_STATE  = state_q;
endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Bench for bin_to_bcd_display: a 20-bit/6-digit blanking instance and a
// 14-bit/4-digit non-blanking instance share clock, reset and stimulus.
module tb_bin_to_bcd_display;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_to_bcd_display_if #(.BIN_W(20), .DIGITS(6)) bus1 ();
    bin_to_bcd_display_if #(.BIN_W(14), .DIGITS(4)) bus2 ();
    logic [1:0] dbg1, dbg2;

    bin_to_bcd_display #(.BIN_W(20), .DIGITS(6), .LZ_BLANK(1'b1)) dut1 (
        .iCLK(clk), .iRST(rst), .conv(bus1), .oDBG_STATE(dbg1)
    );
    bin_to_bcd_display #(.BIN_W(14), .DIGITS(4), .LZ_BLANK(1'b0)) dut2 (
        .iCLK(clk), .iRST(rst), .conv(bus2), .oDBG_STATE(dbg2)
    );

    // Scoreboard state: expected {ovf, blank[5:0], bcd[23:0]} and the cycle
    // in which oDONE must be observed, one queue pair per instance.
    logic [30:0] exp1_q[$];
    logic [30:0] exp2_q[$];
    int          t1_q[$];
    int          t2_q[$];
    int          last_acc1 = -100, last_acc2 = -100;
    int          free1 = 0, free2 = 0;
    bit          mon_en = 1'b0;
    bit          chk_rst = 1'b0;

    // Reference model: decimal digits by division, blanking by counting
    // significant digits.
    function automatic logic [30:0] ref_model(input longint v, input int nd, input bit lz);
        logic [23:0] bcd;
        logic [5:0]  blank;
        bit          ovf;
        longint      lim, t;
        int          sig;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        ovf   = (v > lim - 1);
        bcd   = '0;
        blank = '0;
        if (ovf) begin
            for (int i = 0; i < nd; i++) bcd[4*i +: 4] = 4'h9;
        end else begin
            t = v;
            for (int i = 0; i < nd; i++) begin
                bcd[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
            if (lz) begin
                sig = 1;
                t   = v;
                while (t >= 10) begin
                    t = t / 10;
                    sig++;
                end
                for (int i = sig; i < nd; i++) blank[i] = 1'b1;
            end
        end
        return {ovf, blank, bcd};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Driver: present one cycle of inputs, then update the model for the
    // edge that samples them.
    task automatic drive_cycle(input bit r, input bit start, input logic [19:0] bin);
        int e;
        rst         = r;
        bus1.iSTART = start;
        bus1.iBIN   = bin;
        bus2.iSTART = start;
        bus2.iBIN   = bin[13:0];
        e = cyc + 1;
        @(posedge clk);
        #1;
        if (r) begin
            exp1_q.delete();
            exp2_q.delete();
            t1_q.delete();
            t2_q.delete();
            last_acc1 = -100;
            last_acc2 = -100;
            free1     = e + 1;
            free2     = e + 1;
            chk_rst   = 1'b1;
            mon_en    = 1'b1;
        end else if (start) begin
            if (e >= free1) begin
                exp1_q.push_back(ref_model(longint'(bin), 6, 1'b1));
                t1_q.push_back(e + 20);
                last_acc1 = e;
                free1     = e + 22;
            end
            if (e >= free2) begin
                exp2_q.push_back(ref_model(longint'(bin[13:0]), 4, 1'b0));
                t2_q.push_back(e + 14);
                last_acc2 = e;
                free2     = e + 16;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 20'($urandom));
    endtask

    function automatic logic [19:0] rand_bin();
        case ($urandom_range(0, 3))
            0:       return 20'($urandom_range(0, 999));
            1:       return 20'($urandom_range(0, 999999));
            2:       return 20'($urandom_range(999990, 1000010));
            default: return 20'($urandom_range(0, 20'hFFFFF));
        endcase
    endfunction

    // Monitor: compares against the model on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (chk_rst) begin
                chk_rst = 1'b0;
                check("rst_out1", {1'b0, bus1.oOVF, bus1.oBLANK, bus1.oBCD}, {1'b0, 1'b0, 6'b111110, 24'h0});
                check("rst_out2", {11'h0, bus2.oOVF, bus2.oBLANK, bus2.oBCD}, 32'h0);
            end
            check("busy1", 32'(bus1.oBUSY), 32'((cyc >= last_acc1) && (cyc <= last_acc1 + 20)));
            check("busy2", 32'(bus2.oBUSY), 32'((cyc >= last_acc2) && (cyc <= last_acc2 + 14)));
            if (bus1.oDONE) begin
                if (exp1_q.size() == 0) begin
                    check("spurious_done1", 32'(1), 32'(0));
                end else begin
                    check("result1", {1'b0, bus1.oOVF, bus1.oBLANK, bus1.oBCD}, {1'b0, exp1_q.pop_front()});
                    check("latency1", 32'(cyc), 32'(t1_q.pop_front()));
                end
            end else if (t1_q.size() != 0 && cyc > t1_q[0]) begin
                check("missing_done1", 32'(cyc), 32'(t1_q.pop_front()));
                void'(exp1_q.pop_front());
            end
            if (bus2.oDONE) begin
                if (exp2_q.size() == 0) begin
                    check("spurious_done2", 32'(1), 32'(0));
                end else begin
                    check("result2", {1'b0, bus2.oOVF, 2'b00, bus2.oBLANK, 8'h00, bus2.oBCD}, {1'b0, exp2_q.pop_front()});
                    check("latency2", 32'(cyc), 32'(t2_q.pop_front()));
                end
            end else if (t2_q.size() != 0 && cyc > t2_q[0]) begin
                check("missing_done2", 32'(cyc), 32'(t2_q.pop_front()));
                void'(exp2_q.pop_front());
            end
        end
    end

    logic [19:0] dir_vals [7];

    initial begin
        rst         = 1'b1;
        bus1.iSTART = 1'b0;
        bus1.iBIN   = '0;
        bus2.iSTART = 1'b0;
        bus2.iBIN   = '0;
        dir_vals = '{20'd123456, 20'd0, 20'd905, 20'd999999, 20'd1000000, 20'hFFFFF, 20'd57};
        @(posedge clk);
        #1;

        // Reset
        drive_cycle(1'b1, 1'b0, '0);
        drive_cycle(1'b1, 1'b0, '0);
        idle(2);

        // Directed values, one conversion at a time
        foreach (dir_vals[i]) begin
            drive_cycle(1'b0, 1'b1, dir_vals[i]);
            idle(23);
        end

        // Start while busy is ignored
        drive_cycle(1'b0, 1'b1, 20'd777);
        idle(5);
        drive_cycle(1'b0, 1'b1, 20'd42);
        idle(25);

        // Start held high with changing data
        for (int i = 0; i < 70; i++) drive_cycle(1'b0, 1'b1, rand_bin());
        idle(25);

        // Reset in the middle of a conversion, then a normal one
        drive_cycle(1'b0, 1'b1, 20'd777);
        idle(6);
        drive_cycle(1'b1, 1'b0, '0);
        idle(3);
        drive_cycle(1'b0, 1'b1, 20'd31415);
        idle(25);

        // Random traffic with random gaps and occasional resets
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 19) == 0) drive_cycle(1'b1, 1'b0, '0);
            drive_cycle(1'b0, 1'b1, rand_bin());
            idle($urandom_range(0, 25));
        end
        idle(30);

        check("pending1", 32'(exp1_q.size()), 32'(0));
        check("pending2", 32'(exp2_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
